// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: hazard-unit control
// encodings, bit positions inside en_HD, and the default bubble instruction.
package if_stage_pkg;

  // Bit positions inside en_HD = {en_IF, flush, en_PC}
  localparam int EN_IF_BIT = 2;
  localparam int FLUSH_BIT = 1;
  localparam int EN_PC_BIT = 0;

  // Hazard-unit encodings
  localparam logic [2:0] EN_HD_RUN   = 3'b101;
  localparam logic [2:0] EN_HD_STALL = 3'b010;

  // Instruction word placed into IF/ID on reset or squash
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Fetch addresses are always word aligned
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_sat_counter16.sv
// 16-bit event counter with synchronous reset that sticks at all-ones.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Increment on enable unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC and the IF/ID pipeline register.
// Priority each cycle: reset, then stall, then redirect, then advance.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  en_HD,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic [31:0] Instr_in,
  output logic [31:0] PC_out,
  output logic [31:0] PC4_out_from_IF,
  output logic [31:0] Instr_out_from_IF,
  output logic        Valid_out_from_IF,
  output logic [15:0] Stall_cnt,
  output logic [15:0] Flush_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  logic        en_if;
  logic        en_pc;
  logic        stall;
  logic        take_redirect;
  logic [31:0] pc_plus4;
  logic        unused_flush;

  // The flush bit is driven by the hazard unit for other stages only
  assign unused_flush  = en_HD[FLUSH_BIT];

  assign en_if         = en_HD[EN_IF_BIT];
  assign en_pc         = en_HD[EN_PC_BIT];
  assign stall         = !(en_if && en_pc);
  // A branch seen during a stall re-asserts once the stall clears
  assign take_redirect = !stall && redirect;
  assign pc_plus4      = pc_q + 32'd4;

  // Next-state selection for PC and IF/ID
  always_comb begin
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (stall) begin
      // Each enable acts on its own register group
      if (en_pc) begin
        pc_d = pc_plus4;
      end
      if (en_if) begin
        pc4_d   = pc_plus4;
        instr_d = Instr_in;
        valid_d = 1'b1;
      end
    end else if (take_redirect) begin
      // Squash the instruction fetched this cycle
      pc_d    = align_word(redirect_target);
      pc4_d   = pc_plus4;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      pc4_d   = pc_plus4;
      instr_d = Instr_in;
      valid_d = 1'b1;
    end
  end

  // PC and IF/ID registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      pc4_q   <= 32'd0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (stall),
    .cnt_o (Stall_cnt)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (take_redirect),
    .cnt_o (Flush_cnt)
  );

  assign PC_out            = pc_q;
  assign PC4_out_from_IF   = pc4_q;
  assign Instr_out_from_IF = instr_q;
  assign Valid_out_from_IF = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios, random traffic and
// a long stall run to saturate the stall counter, all against a cycle model.
module tb_if_stage;

  localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] T_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  en_HD;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] Instr_in;
  logic [31:0] PC_out;
  logic [31:0] PC4_out_from_IF;
  logic [31:0] Instr_out_from_IF;
  logic        Valid_out_from_IF;
  logic [15:0] Stall_cnt;
  logic [15:0] Flush_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: what the fetch stage should hold after each cycle
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid;
  int          m_stalls, m_flushes;

  always #5 clk = ~clk;

  // Instruction memory: word at address a is a ^ A5A5_0000
  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign Instr_in = imem(PC_out);

  if_stage #(
    .RESET_PC  (T_RESET_PC),
    .NOP_INSTR (T_NOP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .en_HD             (en_HD),
    .redirect          (redirect),
    .redirect_target   (redirect_target),
    .Instr_in          (Instr_in),
    .PC_out            (PC_out),
    .PC4_out_from_IF   (PC4_out_from_IF),
    .Instr_out_from_IF (Instr_out_from_IF),
    .Valid_out_from_IF (Valid_out_from_IF),
    .Stall_cnt         (Stall_cnt),
    .Flush_cnt         (Flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // One clock cycle: drive inputs, advance the model, compare all outputs
  task automatic step(input logic r, input logic [2:0] e, input logic rd,
                      input logic [31:0] tgt, input bit verbose);
    logic [31:0] old_pc;
    rst = r; en_HD = e; redirect = rd; redirect_target = tgt;
    old_pc = m_pc;
    if (r) begin
      m_pc = T_RESET_PC; m_pc4 = 32'd0; m_instr = T_NOP; m_valid = 1'b0;
      m_stalls = 0; m_flushes = 0;
    end else if (e[2] == 1'b0 || e[0] == 1'b0) begin
      if (e[0]) m_pc = old_pc + 32'd4;
      if (e[2]) begin
        m_pc4 = old_pc + 32'd4; m_instr = imem(old_pc); m_valid = 1'b1;
      end
      if (m_stalls < 65535) m_stalls++;
    end else if (rd) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_pc4 = old_pc + 32'd4; m_instr = T_NOP; m_valid = 1'b0;
      if (m_flushes < 65535) m_flushes++;
    end else begin
      m_pc = old_pc + 32'd4;
      m_pc4 = old_pc + 32'd4; m_instr = imem(old_pc); m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    check("pc",    PC_out,                    m_pc);
    check("pc4",   PC4_out_from_IF,           m_pc4);
    check("instr", Instr_out_from_IF,         m_instr);
    check("valid", {31'd0, Valid_out_from_IF}, {31'd0, m_valid});
    check("stall_cnt", {16'd0, Stall_cnt},    m_stalls[31:0]);
    check("flush_cnt", {16'd0, Flush_cnt},    m_flushes[31:0]);
    if (verbose)
      $display("cyc rst=%b en=%b rd=%b tgt=%h | pc=%h pc4=%h instr=%h v=%b sc=%0d fc=%0d",
               r, e, rd, tgt, PC_out, PC4_out_from_IF, Instr_out_from_IF,
               Valid_out_from_IF, Stall_cnt, Flush_cnt);
  endtask

  logic [2:0] en_tab [10] = '{3'b101, 3'b101, 3'b101, 3'b111, 3'b010,
                              3'b000, 3'b100, 3'b001, 3'b110, 3'b011};

  initial begin
    rst = 1'b1; en_HD = 3'b101; redirect = 1'b0; redirect_target = 32'd0;
    m_pc = '0; m_pc4 = '0; m_instr = '0; m_valid = 1'b0;
    m_stalls = 0; m_flushes = 0;

    // Reset, with redirect and stall both requested to show reset wins
    step(1'b1, 3'b010, 1'b1, 32'h0000_0200, 1'b1);
    step(1'b1, 3'b101, 1'b1, 32'h0000_0200, 1'b1);

    // Run: PC 4, 8; IF/ID shows previous fetch, valid from here on
    step(1'b0, 3'b101, 1'b0, 32'd0, 1'b1);
    step(1'b0, 3'b101, 1'b0, 32'd0, 1'b1);
    // Load-use stall at PC=8 holds everything, then resume to 12
    step(1'b0, 3'b010, 1'b0, 32'd0, 1'b1);
    check("stall_pc_held", PC_out, 32'h0000_0008);
    step(1'b0, 3'b101, 1'b0, 32'd0, 1'b1);
    check("resume_pc", PC_out, 32'h0000_000C);
    // Redirect from PC=12 to 0x100 squashes the slot
    step(1'b0, 3'b101, 1'b1, 32'h0000_0100, 1'b1);
    check("redir_pc", PC_out, 32'h0000_0100);
    // Redirect together with stall is ignored
    step(1'b0, 3'b010, 1'b1, 32'h0000_0400, 1'b1);
    step(1'b0, 3'b101, 1'b0, 32'd0, 1'b1);
    // Wrap at the top of the address space
    step(1'b0, 3'b101, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 3'b101, 1'b0, 32'd0, 1'b1);
    check("wrap_pc", PC_out, 32'h0000_0000);
    // Misaligned target is word aligned
    step(1'b0, 3'b101, 1'b1, 32'h0000_0103, 1'b1);
    check("align_pc", PC_out, 32'h0000_0100);
    step(1'b0, 3'b101, 1'b0, 32'd0, 1'b1);

    // Random traffic, including split enables and occasional reset
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), en_tab[$urandom_range(0, 9)],
           ($urandom_range(0, 3) == 0), $urandom, 1'b1);
    end

    // Long stall run until the stall counter saturates
    step(1'b1, 3'b101, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 65540; i++) begin
      step(1'b0, 3'b010, i[0], $urandom, 1'b0);
    end
    check("stall_sat", {16'd0, Stall_cnt}, 32'h0000_FFFF);
    step(1'b0, 3'b010, 1'b1, 32'h0000_0300, 1'b1);
    // Reset during stall returns everything to reset values
    step(1'b1, 3'b010, 1'b1, 32'h0000_0300, 1'b1);
    step(1'b0, 3'b101, 1'b0, 32'd0, 1'b1);
    check("first_fetch_after_rst", PC4_out_from_IF, T_RESET_PC + 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word inserted into IF/ID on flush or reset.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 en_HD  input  3  hazard-unit control {en_IF, flush, en_PC}; 3'b101 = run, 3'b010 = load-use stall; flush bit (en_HD[1]) is not used by this block.
REQ-006 redirect  input  1  taken branch or jump resolved in ID this cycle.
REQ-007 redirect_target  input  32  next PC when redirect is asserted.
REQ-008 Instr_in  input  32  instruction memory read data for PC_out, combinational same cycle.
REQ-009 PC_out  output  32  current fetch address to instruction memory.
REQ-010 PC4_out_from_IF  output  32  registered PC+4 of the instruction held in IF/ID.
REQ-011 Instr_out_from_IF  output  32  registered instruction held in IF/ID.
REQ-012 Valid_out_from_IF  output  1  registered: 1 = IF/ID holds a real instruction, 0 = bubble.
REQ-013 Stall_cnt  output  16  saturating count of stall cycles since reset.
REQ-014 Flush_cnt  output  16  saturating count of redirect flushes since reset.

Function
REQ-015 Per-cycle priority SHALL be: rst > stall (en_HD[2]==0 or en_HD[0]==0) > redirect > normal advance.
REQ-016 Normal advance (en_HD==3'b101, redirect==0): PC <= PC+4; IF/ID <= {PC+4, Instr_in, valid=1}.
REQ-017 Stall: en_PC==0 holds PC; en_IF==0 holds PC4/Instr/Valid of IF/ID unchanged; the two enables are applied independently.
REQ-018 Redirect during a stall SHALL be ignored; the branch in ID is stalled and re-asserts redirect once the stall clears.
REQ-019 Redirect with no stall: PC <= redirect_target; IF/ID <= {PC+4, NOP_INSTR, valid=0} (one-cycle bubble; the delay slot is squashed).
REQ-020 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 without error.
REQ-021 redirect_target bits [1:0] SHALL be forced to 2'b00 when loaded into PC.
REQ-022 PC_out SHALL equal the PC register (no combinational path from any input).
REQ-023 Stall_cnt SHALL increment by 1 in each cycle REQ-017 applies, saturating at 16'hFFFF.
REQ-024 Flush_cnt SHALL increment by 1 in each cycle REQ-019 applies, saturating at 16'hFFFF.
REQ-025 Latency: an instruction fetched at PC in cycle n SHALL appear on Instr_out_from_IF in cycle n+1 if not stalled.

Reset
REQ-026 On rst: PC=RESET_PC, PC4_out_from_IF=0, Instr_out_from_IF=NOP_INSTR, Valid_out_from_IF=0, Stall_cnt=0, Flush_cnt=0.
REQ-027 rst asserted mid-stall or mid-redirect SHALL override both; the first fetch after rst deasserts is RESET_PC.

Structure
REQ-028 Shared package SHALL hold the en_HD encodings (RUN=3'b101, STALL=3'b010), the bit positions of en_IF/flush/en_PC, and the NOP constant.
REQ-029 One sub-module, sat_counter16 (enable, synchronous reset, saturate), SHALL be instantiated twice for Stall_cnt and Flush_cnt.

Verification
REQ-030 Reset then 4 run cycles with Instr_in=PC^32'hA5A5_0000 -> PC_out 0,4,8,12,16; Instr_out_from_IF lags by one cycle; Valid_out_from_IF=1 from cycle 2.
REQ-031 Stall en_HD=3'b010 for 1 cycle at PC=8 -> PC_out stays 8, IF/ID holds PC4=8 contents, Stall_cnt=1, then resumes at 12.
REQ-032 redirect=1, target=32'h0000_0100 at PC=12 -> next PC_out=32'h100, Valid_out_from_IF=0, Instr_out_from_IF=NOP_INSTR, Flush_cnt=1.
REQ-033 redirect=1 and en_HD=3'b010 same cycle -> PC held, redirect ignored, Flush_cnt unchanged, Stall_cnt incremented.
REQ-034 PC forced to 32'hFFFF_FFFC via redirect then run -> PC_out=32'h0; redirect_target=32'h0000_0103 -> PC_out=32'h100.
REQ-035 rst asserted during stall with Stall_cnt=16'hFFFF (saturated, stays FFFF on further stalls) -> all outputs return to REQ-026 values next cycle.
